line_mem_initiator: RTL and testbench

- Initiator side of the 128-bit line memory interface (read/write/address/wdata/resp/rdata).
- Sits between the cache controller and physical memory.
- Accepts one miss request at a time. Runs an optional dirty-victim writeback, then a line fill, and returns the fill line with a one-cycle done pulse.
- Includes a per-transaction response timeout and an inter-transaction gap that the memory's respond→idle recovery requires.

---
 rtl/line_mem_initiator.sv | 126 ++++++++++++
 tb/tb_line_mem_initiator.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_initiator.sv
// Line-memory initiator: optional victim writeback, then line fill,
// with per-transaction response timeout and writeback-to-fill gap.
module line_mem_initiator #(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_dirty,
  input  logic [15:0]  req_fill_addr,
  input  logic [15:0]  req_wb_addr,
  input  logic [127:0] req_wb_data,
  output logic         done,
  output logic         err,
  output logic [127:0] fill_data,
  output logic         mem_read,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [127:0] mem_wdata,
  input  logic         mem_resp,
  input  logic [127:0] mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WB    = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

  localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [3:0]  ABT_LAST  = 4'(GAP_CYCLES);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam bit          TMO_EN    = (TIMEOUT != 0);

  logic [2:0]  r_state;
  logic [2:0]  w_nxt;
  logic [3:0]  r_gap;
  logic [15:0] r_wait;
  logic [11:0] r_fill_line;
  logic        w_tmo;
  logic        w_unused;

  assign w_unused = ^{req_fill_addr[3:0], req_wb_addr[3:0]};

  // A response on the terminal count wins over the abort.
  assign w_tmo = TMO_EN && !mem_resp && (r_wait == WAIT_LAST);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (req_valid) w_nxt = req_dirty ? S_WB : S_FILL;
      S_WB: begin
        if (mem_resp)   w_nxt = S_GAP;
        else if (w_tmo) w_nxt = S_ABORT;
      end
      S_GAP:   if (r_gap == GAP_LAST) w_nxt = S_FILL;
      S_FILL: begin
        if (mem_resp)   w_nxt = S_DONE;
        else if (w_tmo) w_nxt = S_ABORT;
      end
      S_DONE:  w_nxt = S_IDLE;
      S_ABORT: if (r_gap == ABT_LAST) w_nxt = S_DONE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state != w_nxt) begin
        r_gap  <= '0;
        r_wait <= '0;
      end else begin
        r_gap  <= r_gap + 4'd1;
        r_wait <= r_wait + 16'd1;
      end
    end
  end

  // Outputs are registered from the next state, so they track it Moore-style.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      req_ready <= (w_nxt == S_IDLE);
      done      <= (w_nxt == S_DONE);
      err       <= (w_nxt == S_DONE) && (r_state == S_ABORT);
      mem_read  <= (w_nxt == S_FILL);
      mem_write <= (w_nxt == S_WB);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_line <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      fill_data   <= '0;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_fill_line <= req_fill_addr[15:4];
        if (req_dirty) begin
          mem_address <= {req_wb_addr[15:4], 4'h0};
          mem_wdata   <= req_wb_data;
        end else begin
          mem_address <= {req_fill_addr[15:4], 4'h0};
        end
      end else if (r_state == S_GAP && w_nxt == S_FILL) begin
        mem_address <= {r_fill_line, 4'h0};
      end
      if (r_state == S_FILL && mem_resp) fill_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_line_mem_initiator.sv
// Bench for line_mem_initiator: responding memory, transaction log,
// and a transaction-level expectation model.
module tb_line_mem_initiator;

  localparam int G = 2;
  localparam int T = 8;

  logic         clk, rst;
  logic         req_valid, req_ready, req_dirty;
  logic [15:0]  req_fill_addr, req_wb_addr;
  logic [127:0] req_wb_data;
  logic         done, err;
  logic [127:0] fill_data;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;

  line_mem_initiator #(.GAP_CYCLES(G), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dirty(req_dirty), .req_fill_addr(req_fill_addr),
    .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
    .done(done), .err(err), .fill_data(fill_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
    int           len;
    bit           resp;
    int           idle;
    bit           stable;
  } run_t;

  run_t         log_q[$];
  run_t         cur;
  logic [127:0] mem_m [logic [11:0]];
  logic [127:0] model [logic [11:0]];
  int           cyc, run, last_end, both_cnt;
  int           wr_lat, rd_lat, stale_cyc;
  bit           mute;
  int           checks, errors;

  function automatic logic [127:0] init_line(logic [11:0] l);
    return {8{l, 4'h5}} ^ {4{32'h9E3779B9}};
  endfunction

  function automatic logic [127:0] mdl(logic [11:0] l);
    return model.exists(l) ? model[l] : init_line(l);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory: responds after a programmed latency and logs each request run.
  initial begin
    mem_resp = 1'b0;
    mem_rdata = '0;
    cyc = 0; run = 0; last_end = 0; both_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_resp = 1'b0;
      if (rst) begin
        run = 0;
        continue;
      end
      if (mem_read && mem_write) both_cnt++;
      if (mem_read || mem_write) begin
        if (run == 0) begin
          cur.wr = mem_write;
          cur.addr = mem_address;
          cur.data = mem_write ? mem_wdata : '0;
          cur.idle = cyc - last_end - 1;
          cur.stable = 1'b1;
          cur.resp = 1'b0;
        end else if (mem_write != cur.wr || mem_address != cur.addr ||
                     (cur.wr && mem_wdata != cur.data)) begin
          cur.stable = 1'b0;
        end
        run++;
        cur.len = run;
        if (!mute && run == (cur.wr ? wr_lat : rd_lat)) begin
          mem_resp = 1'b1;
          cur.resp = 1'b1;
          if (cur.wr) mem_m[cur.addr[15:4]] = mem_wdata;
          else mem_rdata = mem_m.exists(cur.addr[15:4]) ?
                           mem_m[cur.addr[15:4]] : init_line(cur.addr[15:4]);
        end
      end else if (run != 0) begin
        log_q.push_back(cur);
        last_end = cyc - 1;
        run = 0;
      end
      if (cyc == stale_cyc) mem_resp = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic issue(input bit d, input logic [15:0] wa,
                       input logic [127:0] wd, input logic [15:0] fa);
    int k;
    k = 0;
    while (!req_ready && k < 100) begin
      tick();
      k++;
    end
    chk("ready_before_req", {127'b0, req_ready}, 1);
    req_dirty = d;
    req_wb_addr = wa;
    req_wb_data = wd;
    req_fill_addr = fa;
    req_valid = 1'b1;
  endtask

  task automatic wait_done(input bit hold, input logic [15:0] nfa,
                           output int n, output logic e);
    n = -1;
    e = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 1) begin
        if (hold) req_fill_addr = nfa;
        else req_valid = 1'b0;
      end
      if (done) begin
        n = i;
        e = err;
        break;
      end
    end
    if (n < 0) begin
      chk("done_seen", {127'b0, done}, 1);
    end else begin
      chk("ready_in_done", {127'b0, req_ready}, 0);
      tick();
      chk("done_one_cycle", {127'b0, done}, 0);
      chk("ready_after_done", {127'b0, req_ready}, 1);
    end
  endtask

  task automatic run_miss(input bit d, input logic [15:0] wa,
                          input logic [127:0] wd, input logic [15:0] fa,
                          input int wl, input int rl);
    int n, exp_n, nr;
    logic e;
    logic [127:0] exp_fill;
    wr_lat = wl;
    rd_lat = rl;
    log_q.delete();
    issue(d, wa, wd, fa);
    wait_done(1'b0, 16'h0, n, e);
    if (d) model[wa[15:4]] = wd;
    exp_fill = mdl(fa[15:4]);
    exp_n = (d ? wl + G : 0) + rl + 1;
    nr = d ? 2 : 1;
    chk("latency", 128'(n), 128'(exp_n));
    chk("err", {127'b0, e}, 0);
    chk("fill_data", fill_data, exp_fill);
    chk("n_runs", 128'(log_q.size()), 128'(nr));
    if (log_q.size() == nr) begin
      if (d) begin
        chk("wb_is_write", {127'b0, log_q[0].wr}, 1);
        chk("wb_addr", {112'b0, log_q[0].addr}, {112'b0, wa[15:4], 4'h0});
        chk("wb_data", log_q[0].data, wd);
        chk("wb_stable", {127'b0, log_q[0].stable}, 1);
        chk("gap_idle", 128'(log_q[1].idle), 128'(G));
      end
      chk("fill_is_read", {127'b0, log_q[nr-1].wr}, 0);
      chk("fill_addr", {112'b0, log_q[nr-1].addr}, {112'b0, fa[15:4], 4'h0});
      chk("fill_stable", {127'b0, log_q[nr-1].stable}, 1);
      chk("fill_len", 128'(log_q[nr-1].len), 128'(rl));
    end
  endtask

  initial begin
    int n, n2;
    logic e, e2;
    logic [127:0] prev, dd;
    checks = 0; errors = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_dirty = 1'b0;
    req_fill_addr = '0; req_wb_addr = '0; req_wb_data = '0;
    mute = 1'b0; wr_lat = 1; rd_lat = 1; stale_cyc = -1;
    mem_m[12'h123] = {16{8'hA5}};
    model[12'h123] = {16{8'hA5}};
    repeat (2) tick();
    chk("rst_ready", {127'b0, req_ready}, 1);
    chk("rst_done", {127'b0, done}, 0);
    chk("rst_err", {127'b0, err}, 0);
    chk("rst_rw", {126'b0, mem_read, mem_write}, 0);
    chk("rst_addr", {112'b0, mem_address}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_fill", fill_data, 0);
    rst = 1'b0;
    tick();

    run_miss(1'b0, 16'h0, '0, 16'h1234, 1, 3);
    chk("clean_a5", fill_data, {16{8'hA5}});
    dd = {4{32'hDEADBEEF}};
    run_miss(1'b1, 16'h2008, dd, 16'h4000, 2, 2);
    run_miss(1'b0, 16'h0, '0, 16'h2000, 1, 1);
    chk("readback", fill_data, dd);

    wr_lat = 1; rd_lat = 2;
    log_q.delete();
    issue(1'b0, 16'h0, '0, 16'h1110);
    wait_done(1'b1, 16'h2220, n, e);
    chk("b2b_lat1", 128'(n), 3);
    wait_done(1'b0, 16'h0, n2, e2);
    chk("b2b_lat2", 128'(n2), 3);
    chk("b2b_err", {126'b0, e, e2}, 0);
    chk("b2b_fill", fill_data, mdl(12'h222));
    chk("b2b_runs", 128'(log_q.size()), 2);
    if (log_q.size() == 2) begin
      chk("b2b_addr0", {112'b0, log_q[0].addr}, 128'h1110);
      chk("b2b_addr1", {112'b0, log_q[1].addr}, 128'h2220);
    end

    mute = 1'b1;
    log_q.delete();
    prev = fill_data;
    issue(1'b0, 16'h0, '0, 16'h3330);
    wait_done(1'b0, 16'h0, n, e);
    chk("tmo_lat", 128'(n), 128'(T + G + 2));
    chk("tmo_err", {127'b0, e}, 1);
    chk("tmo_fill_kept", fill_data, prev);
    chk("tmo_runs", 128'(log_q.size()), 1);
    if (log_q.size() == 1) begin
      chk("tmo_len", 128'(log_q[0].len), 128'(T));
    end
    mute = 1'b0;
    stale_cyc = cyc + 1;
    repeat (3) tick();
    chk("stale_done", {127'b0, done}, 0);
    chk("stale_ready", {127'b0, req_ready}, 1);
    chk("stale_rw", {126'b0, mem_read, mem_write}, 0);

    mute = 1'b1;
    log_q.delete();
    issue(1'b1, 16'h5550, dd, 16'h6660);
    wait_done(1'b0, 16'h0, n, e);
    chk("wbtmo_lat", 128'(n), 128'(T + G + 2));
    chk("wbtmo_err", {127'b0, e}, 1);
    chk("wbtmo_runs", 128'(log_q.size()), 1);
    if (log_q.size() == 1) begin
      chk("wbtmo_wr", {127'b0, log_q[0].wr}, 1);
    end
    mute = 1'b0;

    run_miss(1'b0, 16'h0, '0, 16'h7770, 1, T);

    wr_lat = 6;
    log_q.delete();
    issue(1'b1, 16'h8880, dd, 16'h9990);
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_wb_write", {127'b0, mem_write}, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_write", {127'b0, mem_write}, 0);
    chk("async_rst_ready", {127'b0, req_ready}, 1);
    chk("async_rst_addr", {112'b0, mem_address}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {127'b0, req_ready}, 1);
    run_miss(1'b0, 16'h0, '0, 16'h8880, 1, 2);

    for (int i = 0; i < 8; i++) begin
      run_miss(1'($urandom_range(0, 1)), 16'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
               int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
    end

    chk("never_rw", 128'(both_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
